// File: rtl/pipe_scroller.sv
// Obstacle engine: scrolls NUM_PIPES pipes left on an internal game tick, respawns
// them at the right edge with an LFSR-chosen gap height and counts bird passes.
module pipe_scroller #(
    parameter int unsigned NUM_PIPES    = 2,
    parameter int unsigned X_W          = 11,
    parameter int unsigned SCREEN_W     = 640,
    parameter int unsigned INIT_X       = 319,
    parameter int unsigned PIPE_SPACING = 320,
    parameter int unsigned GAP_RESET    = 240,
    parameter int unsigned GAP_MIN      = 120,
    parameter int unsigned GAP_BITS     = 8,
    parameter int unsigned BIRD_X       = 100,
    parameter int unsigned TICK_DIV     = 1 << 20,
    parameter int unsigned SCORE_W      = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     run,
    input  logic [1:0]               speed,
    input  logic                     clear_score,
    output logic [NUM_PIPES*X_W-1:0] pipe_x,
    output logic [NUM_PIPES*X_W-1:0] pipe_y,
    output logic                     moved,
    output logic                     pass,
    output logic [SCORE_W-1:0]       score
);

    localparam int unsigned CNT_W  = $clog2(TICK_DIV);
    localparam int unsigned PC_W   = $clog2(NUM_PIPES + 1);
    localparam int unsigned SUM_W  = SCORE_W + 1;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    logic [CNT_W-1:0]   tick_cnt;
    logic [15:0]        lfsr;
    logic               tick_c;
    logic [X_W-1:0]     step_c;
    logic [X_W-1:0]     old_x_c;
    logic [X_W-1:0]     next_x_c [NUM_PIPES];
    logic [X_W-1:0]     next_y_c [NUM_PIPES];
    logic [NUM_PIPES-1:0] pass_vec_c;
    logic [PC_W-1:0]    pass_cnt_c;
    logic [SUM_W-1:0]   score_sum_c;
    logic [SCORE_W-1:0] score_next_c;

    // Per-pipe scroll/respawn decision and pass detection for the current tick.
    always_comb begin
        tick_c       = run && (tick_cnt == CNT_W'(TICK_DIV - 1));
        step_c       = X_W'(speed) + X_W'(1);
        old_x_c      = '0;
        pass_vec_c   = '0;
        pass_cnt_c   = '0;
        score_sum_c  = '0;
        score_next_c = score;
        for (int i = 0; i < int'(NUM_PIPES); i++) begin
            old_x_c = pipe_x[i*X_W +: X_W];
            if (old_x_c >= step_c) begin
                next_x_c[i]   = old_x_c - step_c;
                next_y_c[i]   = pipe_y[i*X_W +: X_W];
                pass_vec_c[i] = (old_x_c >= X_W'(BIRD_X)) && (next_x_c[i] < X_W'(BIRD_X));
            end else begin
                next_x_c[i]   = X_W'(SCREEN_W - 1);
                next_y_c[i]   = X_W'(GAP_MIN) + X_W'(lfsr[i +: GAP_BITS]);
                pass_vec_c[i] = 1'b0;
            end
            pass_cnt_c = pass_cnt_c + PC_W'(pass_vec_c[i]);
        end
        score_sum_c = SUM_W'(score) + SUM_W'(pass_cnt_c);
        if (score_sum_c[SCORE_W]) begin
            score_next_c = '1;
        end else begin
            score_next_c = score_sum_c[SCORE_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr     <= LFSR_SEED;
            tick_cnt <= '0;
            moved    <= 1'b0;
            pass     <= 1'b0;
            score    <= '0;
            for (int i = 0; i < int'(NUM_PIPES); i++) begin
                pipe_x[i*X_W +: X_W] <= X_W'(INIT_X + i * PIPE_SPACING);
                pipe_y[i*X_W +: X_W] <= X_W'(GAP_RESET);
            end
        end else begin
            // LFSR free-runs so respawn heights depend on time spent frozen too.
            lfsr  <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            moved <= tick_c;
            pass  <= tick_c && (|pass_vec_c);
            if (run) begin
                tick_cnt <= tick_c ? '0 : tick_cnt + CNT_W'(1);
            end
            if (tick_c) begin
                for (int i = 0; i < int'(NUM_PIPES); i++) begin
                    pipe_x[i*X_W +: X_W] <= next_x_c[i];
                    pipe_y[i*X_W +: X_W] <= next_y_c[i];
                end
            end
            if (clear_score) begin
                score <= '0;
            end else if (tick_c) begin
                score <= score_next_c;
            end
        end
    end

endmodule
